multi_dot_stream: RTL and testbench

- Parametrised successor to the fixed 4x4 checksum dot-product block in the ABFT checker path.
- Computes NUM_VEC dot products in parallel, each one a vector against a shared weight vector e, streamed one element index per beat over ARRAY_SIZE beats.
- Adds valid/ready handshakes on input and output, an internal element counter in place of an external selector, a signed/unsigned mode, and per-channel overflow detection with optional saturation.
- Feeds the checksum comparator that flags faulty systolic-array outputs.

---
 rtl/multi_dot_stream.sv | 148 ++++++++++++++
 tb/tb_multi_dot_stream.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_dot_stream.sv
// Streams NUM_VEC dot products against a shared weight vector, one element per beat.
// Results carry per-channel overflow flags and optionally saturate to the Z_BITS range.
module multi_dot_stream #(
  parameter int ARRAY_SIZE = 4,
  parameter int NUM_VEC    = 4,
  parameter int A_BITS     = 12,
  parameter int Z_BITS     = 28,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_VEC*A_BITS-1:0]   vec_in,
  input  logic [A_BITS-1:0]           e_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_VEC*Z_BITS-1:0]   dot_out,
  output logic [NUM_VEC-1:0]          ovf_out
);

  localparam int CW  = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int PW  = 2 * A_BITS;
  localparam int AW  = Z_BITS + 1;
  localparam int SW  = Z_BITS + 2;
  localparam bit SGN = (SIGNED != 0);
  localparam bit SAT = (SATURATE != 0);
  localparam logic [CW-1:0] LAST = CW'(ARRAY_SIZE - 1);
  localparam logic [SW-1:0] ONE    = SW'(1);
  localparam logic [SW-1:0] S_MAX  = (ONE << (Z_BITS - 1)) - ONE;
  localparam logic [SW-1:0] S_MIN  = ~S_MAX;
  localparam logic [SW-1:0] U_MAX  = (ONE << Z_BITS) - ONE;
  localparam logic [AW-1:0] S_MAX_A = S_MAX[AW-1:0];
  localparam logic [AW-1:0] S_MIN_A = S_MIN[AW-1:0];
  localparam logic [AW-1:0] U_MAX_A = U_MAX[AW-1:0];

  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        busy_q, busy_d;
  logic                        p1_valid_q, p1_first_q, p1_last_q;
  logic [PW-1:0]               prod_q [NUM_VEC];
  logic [PW-1:0]               prod_d [NUM_VEC];
  logic [AW-1:0]               acc_q  [NUM_VEC];
  logic [AW-1:0]               acc_d  [NUM_VEC];
  logic [NUM_VEC-1:0]          ovf_q, ovf_d;
  logic                        out_valid_q, out_valid_d;
  logic [NUM_VEC*Z_BITS-1:0]   dot_q, dot_d;
  logic [NUM_VEC-1:0]          ovf_out_q, ovf_out_d;
  logic                        accept, beat_first, beat_last;
  logic [PW-1:0]               a_x, e_x;
  logic [SW-1:0]               base, addend, sum;
  logic                        add_ovf, hold;

  always_comb begin
    accept     = in_valid && !busy_q;
    beat_first = (cnt_q == '0);
    beat_last  = (cnt_q == LAST);
    cnt_d      = cnt_q;
    if (accept) cnt_d = beat_last ? '0 : cnt_q + CW'(1);

    busy_d = busy_q;
    if (accept && beat_last) busy_d = 1'b1;
    else if (out_valid_q && out_ready) busy_d = 1'b0;

    // Operands extended to the full product width so the low PW bits are exact for both modes.
    e_x = {{(PW-A_BITS){SGN ? e_in[A_BITS-1] : 1'b0}}, e_in};
    a_x = '0;
    for (int i = 0; i < NUM_VEC; i++) begin
      a_x = {{(PW-A_BITS){SGN ? vec_in[i*A_BITS+A_BITS-1] : 1'b0}}, vec_in[i*A_BITS +: A_BITS]};
      prod_d[i] = a_x * e_x;
    end

    base    = '0;
    addend  = '0;
    sum     = '0;
    add_ovf = 1'b0;
    hold    = 1'b0;
    ovf_d   = ovf_q;
    for (int i = 0; i < NUM_VEC; i++) begin
      acc_d[i] = acc_q[i];
      base   = p1_first_q ? '0 : {{(SW-AW){SGN ? acc_q[i][AW-1] : 1'b0}}, acc_q[i]};
      addend = {{(SW-PW){SGN ? prod_q[i][PW-1] : 1'b0}}, prod_q[i]};
      sum    = base + addend;
      add_ovf = SGN ? (($signed(sum) > $signed(S_MAX)) || ($signed(sum) < $signed(S_MIN)))
                    : (sum > U_MAX);
      // A saturated channel stays pinned at its clamp until the next frame starts.
      hold = SAT && !p1_first_q && ovf_q[i];
      if (p1_valid_q) begin
        ovf_d[i] = (p1_first_q ? 1'b0 : ovf_q[i]) | add_ovf;
        if (hold)
          acc_d[i] = acc_q[i];
        else if (SAT && add_ovf)
          acc_d[i] = SGN ? (sum[SW-1] ? S_MIN_A : S_MAX_A) : U_MAX_A;
        else
          acc_d[i] = {{(AW-Z_BITS){SGN ? sum[Z_BITS-1] : 1'b0}}, sum[Z_BITS-1:0]};
      end
    end

    out_valid_d = out_valid_q;
    dot_d       = dot_q;
    ovf_out_d   = ovf_out_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (p1_valid_q && p1_last_q) begin
      out_valid_d = 1'b1;
      ovf_out_d   = ovf_d;
      for (int i = 0; i < NUM_VEC; i++) dot_d[i*Z_BITS +: Z_BITS] = acc_d[i][Z_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_first_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      dot_q       <= '0;
      ovf_out_q   <= '0;
      for (int i = 0; i < NUM_VEC; i++) begin
        prod_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      p1_valid_q  <= accept;
      p1_first_q  <= beat_first;
      p1_last_q   <= beat_last;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      dot_q       <= dot_d;
      ovf_out_q   <= ovf_out_d;
      for (int i = 0; i < NUM_VEC; i++) begin
        if (accept) prod_q[i] <= prod_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign in_ready  = !busy_q;
  assign out_valid = out_valid_q;
  assign dot_out   = dot_q;
  assign ovf_out   = ovf_out_q;

endmodule

// File: tb/tb_multi_dot_stream.sv
// Directed bench for multi_dot_stream: four instances share stimulus, each with a
// different parameter set (default, saturating 24-bit, wrapping 24-bit, unsigned).
module tb_multi_dot_stream;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [47:0]  vec_in = '0;
  logic [11:0]  e_in = '0;

  logic         m_in_ready, m_out_valid;
  logic [111:0] m_dot;
  logic [3:0]   m_ovf;
  logic         s_in_ready, s_out_valid;
  logic [95:0]  s_dot;
  logic [3:0]   s_ovf;
  logic         w_in_ready, w_out_valid;
  logic [95:0]  w_dot;
  logic [3:0]   w_ovf;
  logic         u_in_ready, u_out_valid;
  logic [111:0] u_dot;
  logic [3:0]   u_ovf;

  int n_chk = 0;
  int n_pass = 0;

  logic [47:0] vt [4];
  logic [11:0] et [4];

  localparam logic [111:0] EXP_BASIC   = {28'd10235, 28'd0, 28'hFFFFFBA, 28'd70};
  localparam logic [95:0]  EXP_BASIC24 = {24'd10235, 24'd0, 24'hFFFFBA, 24'd70};
  localparam logic [95:0]  EXP_SAT     = {4{24'h7FFFFF}};
  localparam logic [95:0]  EXP_WRAP    = 96'd0;
  localparam logic [111:0] EXP_UNS     = {4{28'd67076100}};
  localparam logic [111:0] EXP_ONES    = {4{28'd4}};

  always #5 clk = ~clk;

  multi_dot_stream u_main (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(m_in_ready),
    .vec_in(vec_in), .e_in(e_in), .out_valid(m_out_valid), .out_ready(out_ready),
    .dot_out(m_dot), .ovf_out(m_ovf));

  multi_dot_stream #(.Z_BITS(24), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(s_in_ready),
    .vec_in(vec_in), .e_in(e_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .dot_out(s_dot), .ovf_out(s_ovf));

  multi_dot_stream #(.Z_BITS(24), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(w_in_ready),
    .vec_in(vec_in), .e_in(e_in), .out_valid(w_out_valid), .out_ready(out_ready),
    .dot_out(w_dot), .ovf_out(w_ovf));

  multi_dot_stream #(.SIGNED(0)) u_uns (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(u_in_ready),
    .vec_in(vec_in), .e_in(e_in), .out_valid(u_out_valid), .out_ready(out_ready),
    .dot_out(u_dot), .ovf_out(u_ovf));

  task automatic load_basic();
    vt[0] = {12'd2047, 12'd0, 12'hFFF, 12'd1};
    vt[1] = {12'd0,    12'd0, 12'hFFE, 12'd2};
    vt[2] = {12'd0,    12'd0, 12'hFFD, 12'd3};
    vt[3] = {12'd0,    12'd0, 12'hFFC, 12'd4};
    et[0] = 12'd5; et[1] = 12'd6; et[2] = 12'd7; et[3] = 12'd8;
  endtask

  task automatic load_fill(input logic [11:0] v);
    for (int k = 0; k < 4; k++) begin
      vt[k] = {4{v}};
      et[k] = v;
    end
  endtask

  task automatic drive_beat(input int k);
    in_valid = 1'b1;
    vec_in   = vt[k];
    e_in     = et[k];
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    vec_in   = 48'hABCABCABCABC;
    e_in     = 12'h5A5;
  endtask

  // One frame of the loaded table, beats on cycles 0-3, consumer always ready.
  task automatic run_basic(input string tag);
    load_basic();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_beat(c); else drive_idle();
      @(negedge clk);
      n_chk++; if (m_out_valid !== (c == 5)) $display("FAIL %s out_valid c%0d got %b exp %b", tag, c, m_out_valid, (c == 5)); else n_pass++;
      n_chk++; if (m_in_ready !== !(c == 4 || c == 5)) $display("FAIL %s in_ready c%0d got %b exp %b", tag, c, m_in_ready, !(c == 4 || c == 5)); else n_pass++;
      if (c == 5) begin
        n_chk++; if (m_dot !== EXP_BASIC) $display("FAIL %s dot got %h exp %h", tag, m_dot, EXP_BASIC); else n_pass++;
        n_chk++; if (m_ovf !== 4'b0000) $display("FAIL %s ovf got %b exp 0000", tag, m_ovf); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (m_out_valid !== 1'b0) $display("FAIL reset out_valid got %b exp 0", m_out_valid); else n_pass++;
    n_chk++; if (m_dot !== '0) $display("FAIL reset dot got %h exp 0", m_dot); else n_pass++;
    n_chk++; if (m_ovf !== '0) $display("FAIL reset ovf got %b exp 0", m_ovf); else n_pass++;
    #9 rst = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (m_in_ready !== 1'b1) $display("FAIL reset in_ready got %b exp 1", m_in_ready); else n_pass++;
  endtask

  task automatic test_basic();
    run_basic("basic");
  endtask

  task automatic test_backpressure();
    logic exp_v, exp_r;
    load_basic();
    for (int c = 0; c < 16; c++) begin
      if (c < 4) drive_beat(c);
      else if (c >= 9 && c <= 12) drive_beat(c - 9);
      else drive_idle();
      out_ready = !(c >= 5 && c <= 7);
      exp_v = (c >= 5 && c <= 8) || (c == 14);
      exp_r = !((c >= 4 && c <= 8) || (c >= 13 && c <= 14));
      @(negedge clk);
      n_chk++; if (m_out_valid !== exp_v) $display("FAIL bp out_valid c%0d got %b exp %b", c, m_out_valid, exp_v); else n_pass++;
      n_chk++; if (m_in_ready !== exp_r) $display("FAIL bp in_ready c%0d got %b exp %b", c, m_in_ready, exp_r); else n_pass++;
      if (exp_v) begin
        n_chk++; if (m_dot !== EXP_BASIC) $display("FAIL bp dot c%0d got %h exp %h", c, m_dot, EXP_BASIC); else n_pass++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_gaps();
    load_basic();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: drive_beat(0);
        2: drive_beat(1);
        4: drive_beat(2);
        5: drive_beat(3);
        default: drive_idle();
      endcase
      @(negedge clk);
      n_chk++; if (m_out_valid !== (c == 7)) $display("FAIL gaps out_valid c%0d got %b exp %b", c, m_out_valid, (c == 7)); else n_pass++;
      if (c == 7) begin
        n_chk++; if (m_dot !== EXP_BASIC) $display("FAIL gaps dot got %h exp %h", m_dot, EXP_BASIC); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    load_fill(12'h800);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_beat(c); else drive_idle();
      @(negedge clk);
      if (c == 5) begin
        n_chk++; if (s_out_valid !== 1'b1) $display("FAIL ovf_sat out_valid got %b exp 1", s_out_valid); else n_pass++;
        n_chk++; if (s_dot !== EXP_SAT) $display("FAIL ovf_sat dot got %h exp %h", s_dot, EXP_SAT); else n_pass++;
        n_chk++; if (s_ovf !== 4'b1111) $display("FAIL ovf_sat flags got %b exp 1111", s_ovf); else n_pass++;
        n_chk++; if (w_dot !== EXP_WRAP) $display("FAIL ovf_wrap dot got %h exp %h", w_dot, EXP_WRAP); else n_pass++;
        n_chk++; if (w_ovf !== 4'b1111) $display("FAIL ovf_wrap flags got %b exp 1111", w_ovf); else n_pass++;
      end
      @(posedge clk); #1;
    end
    load_basic();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_beat(c); else drive_idle();
      @(negedge clk);
      if (c == 5) begin
        n_chk++; if (s_ovf !== 4'b0000) $display("FAIL ovf_next sat flags got %b exp 0000", s_ovf); else n_pass++;
        n_chk++; if (w_ovf !== 4'b0000) $display("FAIL ovf_next wrap flags got %b exp 0000", w_ovf); else n_pass++;
        n_chk++; if (s_dot !== EXP_BASIC24) $display("FAIL ovf_next sat dot got %h exp %h", s_dot, EXP_BASIC24); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_unsigned();
    load_fill(12'hFFF);
    for (int c = 0; c < 8; c++) begin
      if (c < 4) drive_beat(c); else drive_idle();
      @(negedge clk);
      if (c == 5) begin
        n_chk++; if (u_dot !== EXP_UNS) $display("FAIL uns dot got %h exp %h", u_dot, EXP_UNS); else n_pass++;
        n_chk++; if (u_ovf !== 4'b0000) $display("FAIL uns ovf got %b exp 0000", u_ovf); else n_pass++;
        n_chk++; if (m_dot !== EXP_ONES) $display("FAIL uns signed_ref dot got %h exp %h", m_dot, EXP_ONES); else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clear();
    load_basic();
    drive_beat(0); @(posedge clk); #1;
    drive_beat(1); @(posedge clk); #1;
    drive_beat(2); clear = 1'b1; @(posedge clk); #1;
    clear = 1'b0; drive_idle();
    @(negedge clk);
    n_chk++; if (m_in_ready !== 1'b1) $display("FAIL clear in_ready got %b exp 1", m_in_ready); else n_pass++;
    n_chk++; if (m_out_valid !== 1'b0) $display("FAIL clear out_valid got %b exp 0", m_out_valid); else n_pass++;
    @(posedge clk); #1;
    run_basic("clear_fresh");
    load_basic();
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive_beat(c); else drive_idle();
      clear = (c == 6);
      @(negedge clk);
      if (c == 5) begin
        n_chk++; if (m_out_valid !== 1'b1) $display("FAIL clear_pend out_valid got %b exp 1", m_out_valid); else n_pass++;
      end
      @(posedge clk); #1;
    end
    clear = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (m_out_valid !== 1'b0) $display("FAIL clear_out out_valid got %b exp 0", m_out_valid); else n_pass++;
    n_chk++; if (m_dot !== '0) $display("FAIL clear_out dot got %h exp 0", m_dot); else n_pass++;
    n_chk++; if (m_in_ready !== 1'b1) $display("FAIL clear_out in_ready got %b exp 1", m_in_ready); else n_pass++;
    @(posedge clk); #1;
    run_basic("after_clear");
  endtask

  task automatic test_reset_mid();
    load_basic();
    drive_beat(0); @(posedge clk); #1;
    drive_beat(1); @(posedge clk); #1;
    drive_idle();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    run_basic("rst_midframe");
    load_basic();
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive_beat(c); else drive_idle();
      @(negedge clk);
      if (c == 6) begin
        n_chk++; if (m_out_valid !== 1'b1) $display("FAIL rst_pend out_valid got %b exp 1", m_out_valid); else n_pass++;
      end
      if (c < 6) begin
        @(posedge clk); #1;
      end
    end
    #1 rst = 1'b0;
    #1;
    n_chk++; if (m_out_valid !== 1'b0) $display("FAIL rst_async out_valid got %b exp 0", m_out_valid); else n_pass++;
    n_chk++; if (m_dot !== '0) $display("FAIL rst_async dot got %h exp 0", m_dot); else n_pass++;
    n_chk++; if (m_in_ready !== 1'b1) $display("FAIL rst_async in_ready got %b exp 1", m_in_ready); else n_pass++;
    #1 rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    run_basic("rst_after");
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_basic();
    test_backpressure();
    test_gaps();
    test_overflow();
    test_unsigned();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1, "timeout");
  end

endmodule
